// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NREQ requesters bursts of single-port RAM access.
// Each burst is bounded by MAX_BURST under contention and followed by one turnaround cycle.
module mem_arbiter #(
  parameter int NREQ       = 3,
  parameter int ADD_WIDTH  = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 16,
  localparam int AW = ADD_WIDTH + 1,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*AW-1:0]         addr,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            grant,
  output logic                       ram_cs,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  output logic [OW-1:0]              owner,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic            others;

  // Indices above last_q outrank those at or below it; lowest index wins within each group.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k] && (k <= int'(last_q))) begin
        win_found = 1'b1;
        win_idx   = OW'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k] && (k > int'(last_q))) begin
        win_found = 1'b1;
        win_idx   = OW'(k);
      end
    end
  end

  assign others = |(req & ~grant_q);

  // grant_q is non-zero only in OWN, so it doubles as the RAM port mux select.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        ram_cs    = req[k];
        ram_we    = req[k] & we[k];
        ram_addr  = addr[k*AW +: AW];
        ram_wdata = wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
        if (win_found) begin
          state_d = OWN;
          owner_d = win_idx;
          for (int k = 0; k < NREQ; k++) grant_d[k] = (win_idx == OW'(k));
        end
      end
      OWN: begin
        if (!ram_cs || ((cnt_q == CW'(MAX_BURST - 1)) && others)) begin
          state_d = GAP;
          grant_d = '0;
          owner_d = '0;
          cnt_d   = '0;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = |grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MAX_BURST 4 and 2) share stimulus and are
// each compared every cycle against a burst-level reference model.
module tb_mem_arbiter;

  localparam int NREQ = 3;
  localparam int ADD_WIDTH = 6;
  localparam int DW = 16;
  localparam int AW = ADD_WIDTH + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;

  logic [NREQ-1:0] grant_w [2];
  logic            cs_w    [2];
  logic            rwe_w   [2];
  logic [AW-1:0]   ra_w    [2];
  logic [DW-1:0]   rwd_w   [2];
  logic [1:0]      owner_w [2];
  logic            busy_w  [2];
  logic [1:0]      st_w    [2];

  logic [AW-1:0] a_arr  [NREQ];
  logic [DW-1:0] wd_arr [NREQ];

  // Reference model: who holds the RAM, how many cycles it has used, who went last.
  int holder [2];
  int owned  [2];
  int last   [2];
  int mb     [2] = '{4, 2};

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.NREQ(NREQ), .ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we), .wdata(wdata),
    .grant(grant_w[0]), .ram_cs(cs_w[0]), .ram_we(rwe_w[0]), .ram_addr(ra_w[0]),
    .ram_wdata(rwd_w[0]), .owner(owner_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0])
  );

  mem_arbiter #(.NREQ(NREQ), .ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DW), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we), .wdata(wdata),
    .grant(grant_w[1]), .ram_cs(cs_w[1]), .ram_we(rwe_w[1]), .ram_addr(ra_w[1]),
    .ram_wdata(rwd_w[1]), .owner(owner_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      holder[d] = -1;
      owned[d]  = 0;
      last[d]   = NREQ - 1;
    end
  endtask

  task automatic model_step(input int d, input logic [NREQ-1:0] r);
    int h;
    logic [NREQ-1:0] oth;
    h = holder[d];
    if (h >= 0) begin
      oth = r & ~(NREQ'(1) << h);
      if (((r >> h) & NREQ'(1)) == '0) begin
        last[d] = h;
        holder[d] = -1;
      end else begin
        owned[d]++;
        if ((owned[d] % mb[d] == 0) && (oth != '0)) begin
          last[d] = h;
          holder[d] = -1;
        end
      end
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        int c;
        c = (last[d] + off) % NREQ;
        if (holder[d] < 0 && (((r >> c) & NREQ'(1)) != '0)) begin
          holder[d] = c;
          owned[d] = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [NREQ-1:0] eg;
    logic ecs, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    int eo, h;
    h = holder[d];
    eg = '0; ecs = 1'b0; ewe = 1'b0; ea = '0; ewd = '0; eo = 0;
    if (h >= 0) begin
      eg  = NREQ'(1) << h;
      eo  = h;
      ea  = a_arr[h];
      ewd = wd_arr[h];
      ecs = ((req >> h) & NREQ'(1)) != '0;
      ewe = ecs && (((we >> h) & NREQ'(1)) != '0);
    end
    chk($sformatf("grant%0d", d), grant_w[d], eg);
    chk($sformatf("owner%0d", d), owner_w[d], eo);
    chk($sformatf("busy%0d", d), busy_w[d], h >= 0);
    chk($sformatf("ram_cs%0d", d), cs_w[d], ecs);
    chk($sformatf("ram_we%0d", d), rwe_w[d], ewe);
    chk($sformatf("ram_addr%0d", d), ra_w[d], ea);
    chk($sformatf("ram_wdata%0d", d), rwd_w[d], ewd);
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
    @(negedge clk);
    req = r;
    we  = w;
    for (int k = 0; k < NREQ; k++) begin
      a_arr[k]  = AW'($urandom_range(0, (1 << AW) - 1));
      wd_arr[k] = DW'($urandom);
      addr[k*AW +: AW]  = a_arr[k];
      wdata[k*DW +: DW] = wd_arr[k];
    end
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
  endtask

  task automatic repeat_cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w, input int n);
    for (int i = 0; i < n; i++) cycle(r, w);
  endtask

  // Reset is raised between edges; outputs must clear without any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_grant%0d", d), grant_w[d], 0);
      chk($sformatf("rst_cs%0d", d), cs_w[d], 0);
      chk($sformatf("rst_we%0d", d), rwe_w[d], 0);
      chk($sformatf("rst_busy%0d", d), busy_w[d], 0);
      chk($sformatf("rst_owner%0d", d), owner_w[d], 0);
      chk($sformatf("rst_addr%0d", d), ra_w[d], 0);
    end
    req = '0;
    we  = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      a_arr[k] = '0;
      wd_arr[k] = '0;
    end
    model_reset();
    pulse_reset();

    // Single requester burst, then turnaround and idle.
    repeat_cycle(3'b001, 3'b001, 5);
    repeat_cycle(3'b000, 3'b000, 3);

    // Contention from reset.
    pulse_reset();
    repeat_cycle(3'b011, 3'b010, 3);
    repeat_cycle(3'b010, 3'b010, 4);
    repeat_cycle(3'b000, 3'b000, 2);

    // Pre-emption of a long burst by a later request.
    pulse_reset();
    repeat_cycle(3'b010, 3'b000, 2);
    repeat_cycle(3'b110, 3'b100, 8);
    repeat_cycle(3'b010, 3'b010, 4);
    repeat_cycle(3'b000, 3'b000, 2);

    // Lone requester wraps its counter without a gap.
    repeat_cycle(3'b001, 3'b001, 10);
    repeat_cycle(3'b000, 3'b000, 2);

    // Drop and re-raise while owning.
    repeat_cycle(3'b001, 3'b000, 3);
    cycle(3'b000, 3'b000);
    repeat_cycle(3'b001, 3'b001, 3);
    repeat_cycle(3'b000, 3'b000, 2);

    // Reset mid-burst while requester 2 writes.
    repeat_cycle(3'b100, 3'b100, 4);
    @(negedge clk);
    #1;
    chk("pre_rst_grant", grant_w[0], 3'b100);
    chk("pre_rst_we", rwe_w[0], 1'b1);
    pulse_reset();
    repeat_cycle(3'b101, 3'b000, 4);
    repeat_cycle(3'b000, 3'b000, 2);

    // All requesting continuously.
    repeat_cycle(3'b111, 3'b111, 24);
    repeat_cycle(3'b000, 3'b000, 2);

    // Randomised request patterns with random hold lengths.
    for (int i = 0; i < 80; i++) begin
      logic [NREQ-1:0] r;
      int hold;
      r = NREQ'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) cycle(r, NREQ'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
